// File: rtl/camera_emumod.sv
// OV7670-style parallel video source: PCLK/VSYNC/HREF/DQ timing with RGB565 test patterns,
// high byte first. Stands in for the sensor so the capture path can run without one.
module camera_emumod #(
    parameter int H_PIXELS = 640,
    parameter int H_BLANK  = 144,
    parameter int V_SYNC   = 3,
    parameter int V_BACK   = 17,
    parameter int V_LINES  = 480,
    parameter int V_FRONT  = 10
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        iEn,
    input  logic [1:0]  iMode,
    input  logic [15:0] iColor,
    output logic        CMOS_PCLK,
    output logic        CMOS_VSYNC,
    output logic        CMOS_HREF,
    output logic [7:0]  CMOS_DQ,
    output logic        oDone,
    output logic [15:0] oFrame
);

    localparam int LINE_TICKS = 2 * H_PIXELS + H_BLANK;
    localparam int H_W        = $clog2(LINE_TICKS);
    localparam int BAR_W      = H_PIXELS / 8;
    localparam logic [H_W-1:0] H_LAST     = H_W'(LINE_TICKS - 1);
    localparam logic [H_W-1:0] HREF_TICKS = H_W'(2 * H_PIXELS);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        BACK,
        ACTIVE,
        FRONT
    } state_t;

    state_t      state_reg, state_next;
    logic        phase_reg;
    logic [H_W-1:0] h_reg, h_next;
    logic [15:0] v_reg, v_next;
    logic [15:0] ramp_reg, ramp_next;
    logic [1:0]  mode_reg, mode_next;
    logic [15:0] color_reg, color_next;
    logic        done_reg, done_next;
    logic [15:0] frame_reg, frame_next;

    logic        tick;
    logic        href;
    logic [15:0] v_last;
    logic [7:0]  col_byte;
    logic [15:0] pixel;

    // Timing only advances on the CLOCK edge where PCLK falls.
    assign tick     = phase_reg;
    assign href     = (state_reg == ACTIVE) && (h_reg < HREF_TICKS);
    assign col_byte = 8'(h_reg >> 1);

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_reg <= IDLE;
            phase_reg <= 1'b0;
            h_reg     <= '0;
            v_reg     <= '0;
            ramp_reg  <= '0;
            mode_reg  <= '0;
            color_reg <= '0;
            done_reg  <= 1'b0;
            frame_reg <= '0;
        end else begin
            state_reg <= state_next;
            phase_reg <= ~phase_reg;
            h_reg     <= h_next;
            v_reg     <= v_next;
            ramp_reg  <= ramp_next;
            mode_reg  <= mode_next;
            color_reg <= color_next;
            done_reg  <= done_next;
            frame_reg <= frame_next;
        end
    end

    always_comb begin
        v_last = '0;
        case (state_reg)
            SYNC:    v_last = 16'(V_SYNC - 1);
            BACK:    v_last = 16'(V_BACK - 1);
            ACTIVE:  v_last = 16'(V_LINES - 1);
            FRONT:   v_last = 16'(V_FRONT - 1);
            default: v_last = '0;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        h_next     = h_reg;
        v_next     = v_reg;
        ramp_next  = ramp_reg;
        mode_next  = mode_reg;
        color_next = color_reg;
        done_next  = 1'b0;
        frame_next = frame_reg;
        if (tick) begin
            if (state_reg == IDLE) begin
                if (iEn) begin
                    state_next = SYNC;
                    h_next     = '0;
                    v_next     = '0;
                    ramp_next  = '0;
                    mode_next  = iMode;
                    color_next = iColor;
                end
            end else begin
                // Ramp steps after the low byte of each pixel has been shown.
                if (href && h_reg[0]) begin
                    ramp_next = ramp_reg + 16'd1;
                end
                if (h_reg == H_LAST) begin
                    h_next = '0;
                    if (v_reg == v_last) begin
                        v_next = '0;
                        case (state_reg)
                            SYNC:    state_next = BACK;
                            BACK:    state_next = ACTIVE;
                            ACTIVE:  state_next = FRONT;
                            default: begin
                                state_next = IDLE;
                                done_next  = 1'b1;
                                frame_next = frame_reg + 16'd1;
                            end
                        endcase
                    end else begin
                        v_next = v_reg + 16'd1;
                    end
                end else begin
                    h_next = h_reg + 1'b1;
                end
            end
        end
    end

    always_comb begin
        int bar;
        bar   = int'(h_reg >> 1) / BAR_W;
        pixel = 16'h0000;
        case (mode_reg)
            2'b00: begin
                case (bar)
                    0:       pixel = 16'hFFFF;
                    1:       pixel = 16'hFFE0;
                    2:       pixel = 16'h07FF;
                    3:       pixel = 16'h07E0;
                    4:       pixel = 16'hF81F;
                    5:       pixel = 16'hF800;
                    6:       pixel = 16'h001F;
                    default: pixel = 16'h0000;
                endcase
            end
            2'b01:   pixel = ramp_reg;
            2'b10:   pixel = color_reg;
            default: pixel = {v_reg[7:0], col_byte};
        endcase
    end

    assign CMOS_PCLK  = phase_reg;
    assign CMOS_VSYNC = (state_reg == SYNC);
    assign CMOS_HREF  = href;
    assign CMOS_DQ    = !href ? 8'h00 : (h_reg[0] ? pixel[7:0] : pixel[15:8]);
    assign oDone      = done_reg;
    assign oFrame     = frame_reg;

endmodule

// File: tb/tb_camera_emumod.sv
// Randomized bench for camera_emumod: a frame-offset model predicts every PCLK period's
// VSYNC/HREF/DQ, the oDone pulse and the frame count.
module tb_camera_emumod;

    localparam int H  = 8;
    localparam int HB = 6;
    localparam int VS = 2;
    localparam int VB = 1;
    localparam int VL = 3;
    localparam int VF = 1;
    localparam int LT = 2 * H + HB;
    localparam int FT = (VS + VB + VL + VF) * LT;
    localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                         16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    logic        CLOCK;
    logic        RESET;
    logic        iEn;
    logic [1:0]  iMode;
    logic [15:0] iColor;
    logic        CMOS_PCLK;
    logic        CMOS_VSYNC;
    logic        CMOS_HREF;
    logic [7:0]  CMOS_DQ;
    logic        oDone;
    logic [15:0] oFrame;

    camera_emumod #(
        .H_PIXELS(H), .H_BLANK(HB), .V_SYNC(VS), .V_BACK(VB), .V_LINES(VL), .V_FRONT(VF)
    ) dut (
        .CLOCK(CLOCK), .RESET(RESET), .iEn(iEn), .iMode(iMode), .iColor(iColor),
        .CMOS_PCLK(CMOS_PCLK), .CMOS_VSYNC(CMOS_VSYNC), .CMOS_HREF(CMOS_HREF),
        .CMOS_DQ(CMOS_DQ), .oDone(oDone), .oFrame(oFrame)
    );

    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    int errors = 0;
    int checks = 0;

    // Reference model state: a frame is just an offset into FT ticks.
    logic        busy;
    int          off;
    logic [1:0]  mode_m;
    logic [15:0] color_m;
    logic [15:0] frames;
    logic        done_flag;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // {vsync, href, dq} for a given frame offset.
    function automatic logic [9:0] exp_out(int off_i, logic [1:0] md, logic [15:0] col);
        int ln, h, a, c;
        logic [15:0] pix;
        logic [9:0]  r;
        ln = off_i / LT;
        h  = off_i % LT;
        a  = ln - VS - VB;
        r  = '0;
        if (ln < VS) begin
            r[9] = 1'b1;
        end else if (a >= 0 && a < VL && h < 2 * H) begin
            c = h / 2;
            case (md)
                2'd0:    pix = BARS[c / (H / 8)];
                2'd1:    pix = 16'(a * H + c);
                2'd2:    pix = col;
                default: pix = {8'(a), 8'(c)};
            endcase
            r[8]   = 1'b1;
            r[7:0] = (h % 2 == 0) ? pix[15:8] : pix[7:0];
        end
        return r;
    endfunction

    // One PCLK period: sample both halves, compare, then drive inputs for the next tick edge.
    task automatic step(input logic en, input logic [1:0] md, input logic [15:0] col);
        logic [11:0] lo, hi;
        logic [9:0]  e;
        e = busy ? exp_out(off, mode_m, color_m) : 10'h000;
        @(negedge CLOCK);
        lo = {CMOS_PCLK, oDone, CMOS_VSYNC, CMOS_HREF, CMOS_DQ};
        @(negedge CLOCK);
        hi = {CMOS_PCLK, oDone, CMOS_VSYNC, CMOS_HREF, CMOS_DQ};
        check_eq("tick", {24'h0, lo, hi, oFrame},
                 {24'h0, 1'b0, done_flag, e, 1'b1, 1'b0, e, frames});
        iEn    = en;
        iMode  = md;
        iColor = col;
        done_flag = 1'b0;
        if (!busy) begin
            if (en) begin
                busy    = 1'b1;
                off     = 0;
                mode_m  = md;
                color_m = col;
            end
        end else begin
            off++;
            if (off == FT) begin
                busy      = 1'b0;
                frames    = frames + 16'd1;
                done_flag = 1'b1;
                $display("frame %0d complete mode=%0d color=%h errors=%0d", frames, mode_m, color_m, errors);
            end
        end
    endtask

    task automatic rand_step(input logic en);
        step(en, 2'($urandom), 16'($urandom));
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        iEn   = 1'b0;
        @(negedge CLOCK);
        check_eq("reset_out", {36'h0, CMOS_PCLK, CMOS_VSYNC, CMOS_HREF, CMOS_DQ, oDone, oFrame}, 64'h0);
        repeat (2) @(negedge CLOCK);
        RESET = 1'b0;
        @(negedge CLOCK);
        busy      = 1'b0;
        off       = 0;
        frames    = '0;
        done_flag = 1'b0;
        $display("reset applied");
    endtask

    initial begin
        RESET = 1'b1;
        iEn = 1'b0;
        iMode = 2'd0;
        iColor = 16'h0000;
        busy = 1'b0;
        off = 0;
        mode_m = 2'd0;
        color_m = 16'h0;
        frames = '0;
        done_flag = 1'b0;

        do_reset();
        repeat (50) step(1'b0, 2'd0, 16'h0);

        // Bars frame with inputs scrambled mid-frame, then stays idle.
        step(1'b1, 2'd0, 16'h0);
        repeat (FT + 5) rand_step(1'b0);

        // Ramp, back-to-back frames; iEn drops partway through the third.
        step(1'b1, 2'd1, 16'h0);
        repeat (2 * (FT + 1) + 70) step(1'b1, 2'd1, 16'h0);
        repeat (FT + 5) rand_step(1'b0);

        // Grid and solid colour.
        step(1'b1, 2'd3, 16'h0);
        repeat (FT + 3) rand_step(1'b0);
        step(1'b1, 2'd2, 16'hA5C3);
        repeat (FT + 3) rand_step(1'b0);

        // Fully random enables, modes and colours.
        repeat (4 * (FT + 1)) rand_step($urandom_range(0, 3) != 0);
        repeat (FT + 3) rand_step(1'b0);

        // Reset in the middle of ACTIVE, then a clean restart.
        step(1'b1, 2'd3, 16'h0);
        repeat (80) rand_step(1'b1);
        do_reset();
        step(1'b1, 2'd0, 16'h0);
        repeat (FT + 3) rand_step(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
